// File: rtl/ff256_mult_wb_master.sv
// Wishbone initiator for the GF(256) multiplier responder: write {b,a}, settle, read back product.
// Optional ack timeout abort enabled by defining FF256_MST_TIMEOUT_EN.
module ff256_mult_wb_master #(
    parameter int unsigned BUS_WIDTH      = 1,
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned BE_WIDTH       = 4,
    parameter int unsigned SETTLE_CYCLES  = 2,
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  op_valid,
    output logic                  op_ready,
    input  logic [7:0]            op_a,
    input  logic [7:0]            op_b,
    output logic                  res_valid,
    input  logic                  res_ready,
    output logic [7:0]            res_data,
    output logic                  err_o,
    output logic [BUS_WIDTH-1:0]  adr_o,
    output logic [DATA_WIDTH-1:0] data_o,
    input  logic [DATA_WIDTH-1:0] data_i,
    output logic                  we_o,
    output logic [BE_WIDTH-1:0]   sel_o,
    output logic                  stb_o,
    output logic                  cyc_o,
    input  logic                  ack_i
);

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_WR     = 3'd1;
    localparam logic [2:0] ST_SETTLE = 3'd2;
    localparam logic [2:0] ST_RD     = 3'd3;
    localparam logic [2:0] ST_OUT    = 3'd4;

    localparam int unsigned SET_W = $clog2(SETTLE_CYCLES + 1);

    logic [2:0]            state, state_n;
    logic [7:0]            a_q, a_n, b_q, b_n;
    logic [SET_W-1:0]      settle_cnt, settle_n;
    logic [7:0]            res_data_n;
    logic                  err_n;
    logic                  op_ready_n, res_valid_n, we_n, stb_n;
    logic [BE_WIDTH-1:0]   sel_n;
    logic [DATA_WIDTH-1:0] data_n;
    logic                  unused_data;

`ifdef FF256_MST_TIMEOUT_EN
    localparam int unsigned TO_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [TO_W-1:0]       to_cnt, to_n;
    logic                  to_hit;
    assign to_hit = (to_cnt == TO_W'(TIMEOUT_CYCLES - 1));
`endif

    assign adr_o       = '0;
    assign unused_data = ^data_i;

    // Next-state and next-output logic; bus outputs follow the state being entered
    always_comb begin
        state_n    = state;
        a_n        = a_q;
        b_n        = b_q;
        settle_n   = settle_cnt;
        res_data_n = res_data;
        err_n      = err_o;
`ifdef FF256_MST_TIMEOUT_EN
        to_n       = to_cnt;
`endif
        case (state)
            ST_IDLE: begin
                if (op_valid && op_ready) begin
                    a_n     = op_a;
                    b_n     = op_b;
                    state_n = ST_WR;
                end
            end
            ST_WR: begin
                if (ack_i) begin
                    settle_n = SET_W'(SETTLE_CYCLES - 1);
                    state_n  = ST_SETTLE;
`ifdef FF256_MST_TIMEOUT_EN
                    to_n     = '0;
                end else if (to_hit) begin
                    res_data_n = 8'h00;
                    err_n      = 1'b1;
                    to_n       = '0;
                    state_n    = ST_OUT;
                end else begin
                    to_n = to_cnt + TO_W'(1);
`endif
                end
            end
            ST_SETTLE: begin
                if (settle_cnt == '0) state_n = ST_RD;
                else                  settle_n = settle_cnt - SET_W'(1);
            end
            ST_RD: begin
                if (ack_i) begin
                    res_data_n = data_i[23:16];
                    err_n      = 1'b0;
                    state_n    = ST_OUT;
`ifdef FF256_MST_TIMEOUT_EN
                    to_n       = '0;
                end else if (to_hit) begin
                    res_data_n = 8'h00;
                    err_n      = 1'b1;
                    to_n       = '0;
                    state_n    = ST_OUT;
                end else begin
                    to_n = to_cnt + TO_W'(1);
`endif
                end
            end
            ST_OUT: begin
                if (res_ready) begin
                    err_n   = 1'b0;
                    state_n = ST_IDLE;
                end
            end
            default: state_n = ST_IDLE;
        endcase

        op_ready_n  = (state_n == ST_IDLE);
        res_valid_n = (state_n == ST_OUT);
        stb_n       = (state_n == ST_WR) || (state_n == ST_RD);
        we_n        = (state_n == ST_WR);
        sel_n       = (state_n == ST_WR) ? BE_WIDTH'(4'b0011) :
                      (state_n == ST_RD) ? BE_WIDTH'(4'b1111) : '0;
        data_n      = (state_n == ST_WR) ? DATA_WIDTH'({b_n, a_n}) : '0;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= ST_IDLE;
            a_q        <= '0;
            b_q        <= '0;
            settle_cnt <= '0;
            res_data   <= '0;
            err_o      <= 1'b0;
            op_ready   <= 1'b0;
            res_valid  <= 1'b0;
            stb_o      <= 1'b0;
            cyc_o      <= 1'b0;
            we_o       <= 1'b0;
            sel_o      <= '0;
            data_o     <= '0;
        end else begin
            state      <= state_n;
            a_q        <= a_n;
            b_q        <= b_n;
            settle_cnt <= settle_n;
            res_data   <= res_data_n;
            err_o      <= err_n;
            op_ready   <= op_ready_n;
            res_valid  <= res_valid_n;
            stb_o      <= stb_n;
            cyc_o      <= stb_n;
            we_o       <= we_n;
            sel_o      <= sel_n;
            data_o     <= data_n;
        end
    end

`ifdef FF256_MST_TIMEOUT_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) to_cnt <= '0;
        else        to_cnt <= to_n;
    end
`endif

endmodule

// File: tb/tb_ff256_mult_wb_master.sv
// Randomized self-checking bench for ff256_mult_wb_master with a behavioural Wishbone responder.
module tb_ff256_mult_wb_master;

    localparam int SETTLE = 2;
    localparam int TMO    = 16;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        op_valid = 1'b0;
    logic        op_ready;
    logic [7:0]  op_a = 8'h00;
    logic [7:0]  op_b = 8'h00;
    logic        res_valid;
    logic        res_ready = 1'b1;
    logic [7:0]  res_data;
    logic        err_o;
    logic [0:0]  adr_o;
    logic [31:0] data_o;
    logic [31:0] data_i;
    logic        we_o;
    logic [3:0]  sel_o;
    logic        stb_o;
    logic        cyc_o;
    logic        ack_i;

    int n_checks = 0;
    int n_fail   = 0;

    ff256_mult_wb_master dut (
        .clk(clk), .reset(reset),
        .op_valid(op_valid), .op_ready(op_ready), .op_a(op_a), .op_b(op_b),
        .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data), .err_o(err_o),
        .adr_o(adr_o), .data_o(data_o), .data_i(data_i), .we_o(we_o), .sel_o(sel_o),
        .stb_o(stb_o), .cyc_o(cyc_o), .ack_i(ack_i)
    );

    always #5 clk = ~clk;

    // GF(2^8) product, reduction polynomial x^8+x^4+x^3+x+1
    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        int p = 0;
        int x = int'(a);
        int y = int'(b);
        for (int i = 0; i < 8; i++) begin
            if ((y & 1) != 0) p = p ^ x;
            y = y >> 1;
            x = x << 1;
            if ((x & 'h100) != 0) x = x ^ 'h11B;
        end
        return 8'(p);
    endfunction

    // Behavioural responder
    logic        ack_en = 1'b1;
    int          ack_delay = 0;
    logic        force_rd = 1'b0;
    logic [31:0] forced_word = 32'h0;
    logic [15:0] resp_reg = 16'h0;
    int          wait_cnt = 0;

    assign ack_i  = cyc_o && stb_o && ack_en && (wait_cnt >= ack_delay);
    assign data_i = (cyc_o && stb_o && !we_o) ?
                    (force_rd ? forced_word : {8'h00, gf_mul(resp_reg[15:8], resp_reg[7:0]), resp_reg}) :
                    32'h0;

    always @(posedge clk) begin
        if (cyc_o && stb_o && !ack_i) wait_cnt <= wait_cnt + 1;
        else                          wait_cnt <= 0;
        if (cyc_o && stb_o && we_o && ack_i) resp_reg <= data_o[15:0];
    end

    // Bus monitor
    int          cyc_num = 0;
    int          wr_cnt = 0, rd_cnt = 0, stb_cycles = 0, idle_run = 0, last_gap = -1, hold_err = 0;
    logic [31:0] last_wr_data = 32'h0, prev_data = 32'h0;
    logic [3:0]  last_wr_sel = 4'h0, last_rd_sel = 4'h0, prev_sel = 4'h0;
    logic        prev_stb = 1'b0, prev_ack = 1'b0, prev_we = 1'b0;

    always @(posedge clk) cyc_num <= cyc_num + 1;

    always @(negedge clk) begin
        if (stb_o) begin
            stb_cycles <= stb_cycles + 1;
            idle_run   <= 0;
            if (!prev_stb && !we_o) last_gap <= idle_run;
            if (prev_stb && !prev_ack &&
                (data_o !== prev_data || we_o !== prev_we || sel_o !== prev_sel || cyc_o !== 1'b1))
                hold_err <= hold_err + 1;
            if (ack_i) begin
                if (we_o) begin
                    wr_cnt       <= wr_cnt + 1;
                    last_wr_data <= data_o;
                    last_wr_sel  <= sel_o;
                end else begin
                    rd_cnt      <= rd_cnt + 1;
                    last_rd_sel <= sel_o;
                end
            end
        end else begin
            idle_run <= idle_run + 1;
        end
        prev_stb  <= stb_o;
        prev_ack  <= ack_i;
        prev_we   <= we_o;
        prev_sel  <= sel_o;
        prev_data <= data_o;
    end

    task automatic drive_op(input logic [7:0] a, input logic [7:0] b, output bit ok, output int t_acc);
        ok = 1'b0;
        t_acc = 0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            op_a = a;
            op_b = b;
            op_valid = 1'b1;
            if (op_ready) begin
                ok = 1'b1;
                t_acc = cyc_num;
                break;
            end
        end
        if (ok) begin
            @(posedge clk);
            #1;
        end
        op_valid = 1'b0;
    endtask

    task automatic wait_res(input int budget, output bit got, output int lat);
        got = 1'b0;
        lat = 0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            lat++;
            if (res_valid) begin
                got = 1'b1;
                break;
            end
        end
        #1;
    endtask

    task automatic finish_handshake();
        res_ready = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        @(negedge clk);
        reset = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_reset();
        reset = 1'b0;
        #12;
        n_checks++;
        if ({op_ready, res_valid, res_data, err_o, adr_o, data_o, we_o, sel_o, stb_o, cyc_o} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: got op_ready=%b res_valid=%b res_data=%h err=%b data_o=%h we=%b sel=%h stb=%b cyc=%b, want all 0",
                     op_ready, res_valid, res_data, err_o, data_o, we_o, sel_o, stb_o, cyc_o);
        end
        @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        n_checks++;
        if (op_ready !== 1'b1 || stb_o !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_idle: op_ready=%b stb=%b, want 1/0", op_ready, stb_o);
        end
    endtask

    task automatic test_basic();
        bit ok, got;
        int lat, t0, w0, r0;
        w0 = wr_cnt; r0 = rd_cnt;
        res_ready = 1'b1;
        drive_op(8'h01, 8'h53, ok, t0);
        wait_res(40, got, lat);
        n_checks++;
        if (!ok || !got || res_data !== 8'h53 || err_o !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_result: ok=%0d got=%0d res=%h err=%b, want res=53 err=0", ok, got, res_data, err_o);
        end
        n_checks++;
        if (lat != 3 + SETTLE) begin
            n_fail++;
            $display("FAIL basic_latency: %0d cycles, want %0d", lat, 3 + SETTLE);
        end
        n_checks++;
        if (wr_cnt - w0 != 1 || rd_cnt - r0 != 1) begin
            n_fail++;
            $display("FAIL basic_transfers: writes=%0d reads=%0d, want 1/1", wr_cnt - w0, rd_cnt - r0);
        end
        n_checks++;
        if (last_wr_data !== 32'h0000_5301 || last_wr_sel !== 4'b0011 || last_rd_sel !== 4'b1111 || adr_o !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_bus: wdata=%h wsel=%b rsel=%b adr=%b, want 00005301/0011/1111/0",
                     last_wr_data, last_wr_sel, last_rd_sel, adr_o);
        end
        finish_handshake();
    endtask

    task automatic test_forced_read();
        bit ok, got;
        int lat, t0;
        force_rd = 1'b1;
        forced_word = 32'h00A5_8702;
        drive_op(8'h02, 8'h87, ok, t0);
        wait_res(40, got, lat);
        n_checks++;
        if (!got || res_data !== 8'hA5) begin
            n_fail++;
            $display("FAIL forced_read: got=%0d res=%h, want A5", got, res_data);
        end
        n_checks++;
        if (last_gap != SETTLE) begin
            n_fail++;
            $display("FAIL settle_gap: %0d idle cycles, want %0d", last_gap, SETTLE);
        end
        finish_handshake();
        force_rd = 1'b0;
    endtask

    task automatic test_stall();
        bit ok, got, bad;
        int lat, t0, s0;
        logic [7:0] held;
        res_ready = 1'b0;
        drive_op(8'h0E, 8'h0B, ok, t0);
        wait_res(40, got, lat);
        held = res_data;
        s0 = stb_cycles;
        bad = !got;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (res_valid !== 1'b1 || res_data !== held || op_ready !== 1'b0 || stb_o !== 1'b0 || cyc_o !== 1'b0)
                bad = 1'b1;
        end
        #1;
        n_checks++;
        if (bad || stb_cycles != s0 || held !== gf_mul(8'h0E, 8'h0B)) begin
            n_fail++;
            $display("FAIL stall_hold: res_valid=%b res=%h op_ready=%b stb=%b extra_stb=%0d, want 1/%h/0/0/0",
                     res_valid, res_data, op_ready, stb_o, stb_cycles - s0, gf_mul(8'h0E, 8'h0B));
        end
        finish_handshake();
        n_checks++;
        if (res_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL stall_release: res_valid=%b, want 0", res_valid);
        end
    endtask

    task automatic test_ack_delay();
        bit ok, got;
        int lat, t0, h0, s0;
        h0 = hold_err; s0 = stb_cycles;
        ack_delay = 3;
        drive_op(8'h57, 8'h83, ok, t0);
        wait_res(60, got, lat);
        n_checks++;
        if (!got || res_data !== 8'hC1) begin
            n_fail++;
            $display("FAIL ack_delay_result: got=%0d res=%h, want C1", got, res_data);
        end
        n_checks++;
        if (hold_err != h0 || stb_cycles - s0 != 8) begin
            n_fail++;
            $display("FAIL ack_delay_hold: hold_errors=%0d strobe_cycles=%0d, want 0/8", hold_err - h0, stb_cycles - s0);
        end
        finish_handshake();
        ack_delay = 0;
    endtask

    task automatic test_random();
        logic [7:0] q[$];
        logic [7:0] a, b, exp_v;
        bit ok, got;
        int lat, t0, bad, h0;
        bad = 0;
        h0 = hold_err;
        for (int n = 0; n < 24; n++) begin
            a = 8'($urandom);
            b = 8'($urandom);
            ack_delay = $urandom_range(0, 3);
            q.push_back(gf_mul(a, b));
            res_ready = 1'b0;
            drive_op(a, b, ok, t0);
            wait_res(60, got, lat);
            repeat ($urandom_range(0, 2)) @(negedge clk);
            exp_v = q.pop_front();
            n_checks++;
            if (!got || res_data !== exp_v || err_o !== 1'b0 || last_wr_data !== {16'h0, b, a}) begin
                n_fail++;
                bad++;
                $display("FAIL random_%0d: a=%h b=%h res=%h err=%b wdata=%h, want res=%h err=0 wdata=%h",
                         n, a, b, res_data, err_o, last_wr_data, exp_v, {16'h0, b, a});
            end
            finish_handshake();
        end
        n_checks++;
        if (hold_err != h0) begin
            n_fail++;
            $display("FAIL random_hold: %0d strobe hold violations, want 0", hold_err - h0);
        end
        ack_delay = 0;
    endtask

    task automatic test_back_to_back();
        bit ok, got;
        int lat, t0, t1;
        res_ready = 1'b1;
        drive_op(8'h11, 8'h22, ok, t0);
        wait_res(40, got, lat);
        @(posedge clk);
        #1;
        drive_op(8'h33, 8'h44, ok, t1);
        n_checks++;
        if (!ok || t1 - t0 != 4 + SETTLE) begin
            n_fail++;
            $display("FAIL throughput: accept spacing %0d cycles, want %0d", t1 - t0, 4 + SETTLE);
        end
        wait_res(40, got, lat);
        n_checks++;
        if (!got || res_data !== gf_mul(8'h33, 8'h44)) begin
            n_fail++;
            $display("FAIL back_to_back_result: res=%h, want %h", res_data, gf_mul(8'h33, 8'h44));
        end
        finish_handshake();
    endtask

    task automatic test_timeout();
        bit ok, got;
        int lat, t0, s0;
        ack_en = 1'b0;
        s0 = stb_cycles;
        drive_op(8'h09, 8'h07, ok, t0);
`ifdef FF256_MST_TIMEOUT_EN
        wait_res(60, got, lat);
        n_checks++;
        if (!got || res_data !== 8'h00 || err_o !== 1'b1 || stb_cycles - s0 != TMO || stb_o !== 1'b0) begin
            n_fail++;
            $display("FAIL timeout_abort: got=%0d res=%h err=%b strobe_cycles=%0d stb=%b, want 1/00/1/%0d/0",
                     got, res_data, err_o, stb_cycles - s0, stb_o, TMO);
        end
        finish_handshake();
        n_checks++;
        if (err_o !== 1'b0 || res_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL timeout_clear: err=%b res_valid=%b, want 0/0", err_o, res_valid);
        end
        ack_en = 1'b1;
`else
        repeat (40) @(negedge clk);
        #1;
        n_checks++;
        if (stb_o !== 1'b1 || we_o !== 1'b1 || res_valid !== 1'b0 || err_o !== 1'b0 || stb_cycles - s0 != 40) begin
            n_fail++;
            $display("FAIL no_timeout_wait: stb=%b we=%b res_valid=%b err=%b strobe_cycles=%0d, want 1/1/0/0/40",
                     stb_o, we_o, res_valid, err_o, stb_cycles - s0);
        end
        ack_en = 1'b1;
        apply_reset();
`endif
    endtask

    task automatic test_reset_mid();
        bit ok, got, seen;
        int lat, t0;
        ack_delay = 5;
        drive_op(8'h25, 8'h4A, ok, t0);
        seen = 1'b0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (stb_o && !we_o) begin
                seen = 1'b1;
                break;
            end
        end
        #2;
        reset = 1'b0;
        #1;
        n_checks++;
        if (!seen || cyc_o !== 1'b0 || stb_o !== 1'b0 || res_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_mid_rd: in_read=%0d cyc=%b stb=%b res_valid=%b, want 1/0/0/0", seen, cyc_o, stb_o, res_valid);
        end
        ack_delay = 0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        drive_op(8'hCA, 8'h53, ok, t0);
        wait_res(40, got, lat);
        n_checks++;
        if (!got || res_data !== gf_mul(8'hCA, 8'h53) || err_o !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_recover: res=%h err=%b, want %h/0", res_data, err_o, gf_mul(8'hCA, 8'h53));
        end
        finish_handshake();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_forced_read();
        test_stall();
        test_ack_delay();
        test_random();
        test_back_to_back();
        test_timeout();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
